// File: rtl/count_event_fifo_pkg.sv
// Shared constants for the count-event FIFO slice.
//   COUNT_W        : width of the registered counter value seen downstream
//   EVT_FIFO_DEPTH : default number of buffered change events
//   level_w()      : width needed to hold an occupancy of 0..depth
package count_event_fifo_pkg;

  localparam int COUNT_W        = 5;
  localparam int EVT_FIFO_DEPTH = 4;

  function automatic int level_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  localparam int EVT_LEVEL_W = level_w(EVT_FIFO_DEPTH);

endpackage

// File: rtl/count_change_det.sv
// Change detector for the registered counter value.
//   clk, rst   : clock and asynchronous active-low reset
//   capture_en : when high, track data_in and flag any difference
//   data_in    : registered counter value
//   change     : combinational; high when capture_en and data_in differs
//                from the last captured value
module count_change_det
  import count_event_fifo_pkg::*;
#(
  parameter int WIDTH = COUNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             capture_en,
  input  logic [WIDTH-1:0] data_in,
  output logic             change
);

  logic [WIDTH-1:0] last_data;

  // last_data keeps tracking even when the push is rejected, so a dropped
  // value is not re-reported on the following cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_data <= '0;
    end else if (capture_en) begin
      last_data <= data_in;
    end
  end

  assign change = capture_en && (data_in != last_data);

endmodule

// File: rtl/count_event_fifo.sv
// Buffers every change of the registered counter value in a small FIFO and
// drains it with a valid/ready handshake.
//   clk, rst   : clock and asynchronous active-low reset
//   data_in    : registered counter value
//   capture_en : enables change detection and push
//   clr_ovf    : synchronous clear of the sticky overflow flag
//   out_ready  : downstream accepts the head entry
//   out_valid  : head entry present (== !empty)
//   out_data   : head entry
//   full/empty : occupancy decodes
//   level      : occupancy 0..DEPTH
//   overflow   : sticky; a detected change was dropped while full
// DEPTH must be a power of two and at least 2 so pointers wrap naturally.
module count_event_fifo
  import count_event_fifo_pkg::*;
#(
  parameter int WIDTH = COUNT_W,
  parameter int DEPTH = EVT_FIFO_DEPTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     data_in,
  input  logic                 capture_en,
  input  logic                 clr_ovf,
  input  logic                 out_ready,
  output logic                 out_valid,
  output logic [WIDTH-1:0]     out_data,
  output logic                 full,
  output logic                 empty,
  output logic [$clog2(DEPTH):0] level,
  output logic                 overflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = level_w(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [LVL_W-1:0] level_reg;
  logic             overflow_reg;

  logic change;
  logic pop;
  logic push;
  logic reject;

  count_change_det #(
    .WIDTH(WIDTH)
  ) u_det (
    .clk       (clk),
    .rst       (rst),
    .capture_en(capture_en),
    .data_in   (data_in),
    .change    (change)
  );

  assign empty = (level_reg == '0);
  assign full  = (level_reg == LVL_W'(DEPTH));

  assign pop    = !empty && out_ready;
  // When full, a same-cycle pop frees the slot being written.
  assign push   = change && (!full || pop);
  assign reject = change && full && !pop;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      level_reg    <= '0;
      overflow_reg <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   level_reg <= level_reg + 1'b1;
        2'b01:   level_reg <= level_reg - 1'b1;
        default: level_reg <= level_reg;
      endcase
      // A drop in the same cycle as a clear must remain visible.
      if (reject) begin
        overflow_reg <= 1'b1;
      end else if (clr_ovf) begin
        overflow_reg <= 1'b0;
      end
    end
  end

  // Storage is not reset; only the pointers define which entries are live.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= data_in;
    end
  end

  assign out_valid = !empty;
  assign out_data  = mem[rd_ptr];
  assign level     = level_reg;
  assign overflow  = overflow_reg;

endmodule

// File: tb/tb_count_event_fifo.sv
module tb_count_event_fifo;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [4:0] data_in = '0;
  logic       capture_en = 1'b0;
  logic       clr_ovf = 1'b0;
  logic       out_ready = 1'b0;
  logic       out_valid;
  logic [4:0] out_data;
  logic       full;
  logic       empty;
  logic [2:0] level;
  logic       overflow;

  count_event_fifo #(.WIDTH(5), .DEPTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .data_in   (data_in),
    .capture_en(capture_en),
    .clr_ovf   (clr_ovf),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .full      (full),
    .empty     (empty),
    .level     (level),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model / scoreboard
  logic [4:0] m_q[$];
  logic [4:0] m_last = '0;
  logic       m_ovf = 1'b0;
  logic [4:0] drained[$];

  typedef struct {
    logic [4:0] d;
    logic       cap;
    logic       rdy;
    logic       clr;
    int         lvl;
    logic       ful;
    logic       emp;
    logic       ovf;
  } vec_t;

  vec_t tbl[16];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    @(negedge clk);
    check("rst_level", int'(level), 0);
    check("rst_empty", int'(empty), 1);
    check("rst_full", int'(full), 0);
    check("rst_valid", int'(out_valid), 0);
    check("rst_ovf", int'(overflow), 0);
    m_q.delete();
    drained.delete();
    m_last = '0;
    m_ovf  = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    $display("reset applied: level=%0d empty=%0b ovf=%0b", level, empty, overflow);
  endtask

  // One clock cycle: drive inputs, score the pop before the edge, update the
  // model, then compare status after the edge.
  task automatic cycle(input logic [4:0] d, input logic cap, input logic rdy,
                       input logic clr);
    logic chg, pop, acc, rej;
    data_in = d; capture_en = cap; out_ready = rdy; clr_ovf = clr;
    @(negedge clk);
    check("valid_pre", int'(out_valid), int'(m_q.size() != 0));
    chg = cap && (d != m_last);
    pop = (m_q.size() != 0) && rdy;
    acc = chg && ((m_q.size() < 4) || pop);
    rej = chg && !acc;
    if (pop) begin
      logic [4:0] exp_v;
      exp_v = m_q.pop_front();
      check("pop_data", int'(out_data), int'(exp_v));
      drained.push_back(out_data);
    end
    if (acc) m_q.push_back(d);
    if (rej) m_ovf = 1'b1;
    else if (clr) m_ovf = 1'b0;
    if (cap) m_last = d;
    @(posedge clk);
    #1;
    check("level", int'(level), m_q.size());
    check("full", int'(full), int'(m_q.size() == 4));
    check("empty", int'(empty), int'(m_q.size() == 0));
    check("overflow", int'(overflow), int'(m_ovf));
    if (m_q.size() != 0) check("head", int'(out_data), int'(m_q[0]));
    $display("d=%0d cap=%0b rdy=%0b clr=%0b pop=%0b -> level=%0d valid=%0b head=%0d ovf=%0b",
             d, cap, rdy, clr, pop, level, out_valid, out_data, overflow);
  endtask

  task automatic check_drain(input string name, input logic [4:0] exp[8], input int n);
    check({name, "_count"}, drained.size(), n);
    for (int i = 0; i < n && i < drained.size(); i++)
      check($sformatf("%s_%0d", name, i), int'(drained[i]), int'(exp[i]));
  endtask

  task automatic run_rows(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      cycle(tbl[i].d, tbl[i].cap, tbl[i].rdy, tbl[i].clr);
      check($sformatf("row%0d_level", i), int'(level), tbl[i].lvl);
      check($sformatf("row%0d_full", i), int'(full), int'(tbl[i].ful));
      check($sformatf("row%0d_empty", i), int'(empty), int'(tbl[i].emp));
      check($sformatf("row%0d_ovf", i), int'(overflow), int'(tbl[i].ovf));
    end
  endtask

  initial begin
    logic [4:0] exp[8];

    // change filter: 0,3,3,3,4,4 with out_ready low
    tbl[0]  = '{5'd0, 1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b1, 1'b0};
    tbl[1]  = '{5'd3, 1'b1, 1'b0, 1'b0, 1, 1'b0, 1'b0, 1'b0};
    tbl[2]  = '{5'd3, 1'b1, 1'b0, 1'b0, 1, 1'b0, 1'b0, 1'b0};
    tbl[3]  = '{5'd3, 1'b1, 1'b0, 1'b0, 1, 1'b0, 1'b0, 1'b0};
    tbl[4]  = '{5'd4, 1'b1, 1'b0, 1'b0, 2, 1'b0, 1'b0, 1'b0};
    tbl[5]  = '{5'd4, 1'b1, 1'b0, 1'b0, 2, 1'b0, 1'b0, 1'b0};
    // full, overflow, clear, drain
    tbl[6]  = '{5'd1, 1'b1, 1'b0, 1'b0, 1, 1'b0, 1'b0, 1'b0};
    tbl[7]  = '{5'd2, 1'b1, 1'b0, 1'b0, 2, 1'b0, 1'b0, 1'b0};
    tbl[8]  = '{5'd3, 1'b1, 1'b0, 1'b0, 3, 1'b0, 1'b0, 1'b0};
    tbl[9]  = '{5'd4, 1'b1, 1'b0, 1'b0, 4, 1'b1, 1'b0, 1'b0};
    tbl[10] = '{5'd5, 1'b1, 1'b0, 1'b0, 4, 1'b1, 1'b0, 1'b1};
    tbl[11] = '{5'd5, 1'b1, 1'b0, 1'b1, 4, 1'b1, 1'b0, 1'b0};
    tbl[12] = '{5'd5, 1'b1, 1'b1, 1'b0, 3, 1'b0, 1'b0, 1'b0};
    tbl[13] = '{5'd5, 1'b1, 1'b1, 1'b0, 2, 1'b0, 1'b0, 1'b0};
    tbl[14] = '{5'd5, 1'b1, 1'b1, 1'b0, 1, 1'b0, 1'b0, 1'b0};
    tbl[15] = '{5'd5, 1'b1, 1'b1, 1'b0, 0, 1'b0, 1'b1, 1'b0};

    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // Change filter
    run_rows(0, 5);
    cycle(5'd4, 1'b1, 1'b1, 1'b0);
    cycle(5'd4, 1'b1, 1'b1, 1'b0);
    exp = '{5'd3, 5'd4, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0};
    check_drain("filter", exp, 2);

    // Full, overflow, clear, drain
    do_reset();
    run_rows(6, 15);
    exp = '{5'd1, 5'd2, 5'd3, 5'd4, 5'd0, 5'd0, 5'd0, 5'd0};
    check_drain("ovf_drain", exp, 4);

    // Reset mid-operation
    do_reset();
    cycle(5'd1, 1'b1, 1'b0, 1'b0);
    cycle(5'd2, 1'b1, 1'b0, 1'b0);
    cycle(5'd3, 1'b1, 1'b0, 1'b0);
    check("mid_level3", int'(level), 3);
    do_reset();
    cycle(5'd0, 1'b1, 1'b0, 1'b0);
    cycle(5'd7, 1'b1, 1'b0, 1'b0);
    check("after_rst_valid", int'(out_valid), 1);
    check("after_rst_data", int'(out_data), 7);

    // Simultaneous push and pop while full
    do_reset();
    for (int v = 1; v <= 4; v++) cycle(5'(v), 1'b1, 1'b0, 1'b0);
    check("pp_full", int'(full), 1);
    cycle(5'd9, 1'b1, 1'b1, 1'b0);
    check("pp_level", int'(level), 4);
    check("pp_ovf", int'(overflow), 0);
    repeat (4) cycle(5'd9, 1'b1, 1'b1, 1'b0);
    exp = '{5'd1, 5'd2, 5'd3, 5'd4, 5'd9, 5'd0, 5'd0, 5'd0};
    check_drain("pp_drain", exp, 5);

    // Wrap-around of pointers and of the counter value
    do_reset();
    for (int v = 26; v <= 33; v++) cycle(5'(v), 1'b1, 1'b1, 1'b0);
    repeat (2) cycle(5'd1, 1'b1, 1'b1, 1'b0);
    exp = '{5'd26, 5'd27, 5'd28, 5'd29, 5'd30, 5'd31, 5'd0, 5'd1};
    check_drain("wrap", exp, 8);
    check("wrap_ovf", int'(overflow), 0);

    // Capture gating
    do_reset();
    cycle(5'd5, 1'b0, 1'b0, 1'b0);
    cycle(5'd6, 1'b0, 1'b0, 1'b0);
    check("gate_level0", int'(level), 0);
    cycle(5'd6, 1'b1, 1'b0, 1'b0);
    check("gate_level1", int'(level), 1);
    check("gate_data", int'(out_data), 6);

    // Random traffic against the scoreboard
    do_reset();
    for (int i = 0; i < 300; i++) begin
      logic [4:0] d;
      d = ($urandom_range(0, 2) == 0) ? m_last : 5'($urandom_range(0, 31));
      cycle(d, $urandom_range(0, 5) != 0, $urandom_range(0, 1) == 1,
            $urandom_range(0, 7) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
